// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage. It owns the program counter and feeds the external
// PC+4 adder. It fetches over a single-cycle req/ack memory handshake and holds
// one instruction for decode behind a valid/ready handshake. Branch/jump
// redirects from later stages are accepted in any state.
//
// Parameters
//   n         PC/address width (at least 3); must match the attached adder
//   RESET_PC  PC loaded on reset; must be 4-byte aligned
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   redirect, redirect_pc    taken branch/jump and its target
//   add_a, add_b, add_sum    adder operands (PC, 4) and its combinational sum
//   imem_req, imem_addr      fetch request and address (= PC)
//   imem_ack, imem_rdata     memory returns the instruction this cycle
//   out_valid, out_ready     decode handshake
//   out_instr, out_pc        buffered instruction and its PC
//   out_pc4                  out_pc + 4, captured from the adder
//   align_err                sticky: a misaligned redirect target was seen
//   fetch_count              instructions accepted by decode (wraps)
module fetch_stage #(
  parameter int unsigned   n        = 32,
  parameter logic [n-1:0]  RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,
  output logic [n-1:0] add_a,
  output logic [n-1:0] add_b,
  input  logic [n-1:0] add_sum,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_instr,
  output logic [n-1:0] out_pc,
  output logic [n-1:0] out_pc4,
  output logic         align_err,
  output logic [n-1:0] fetch_count
);

  localparam logic [n-1:0] ONE  = {{(n-1){1'b0}}, 1'b1};
  localparam logic [n-1:0] FOUR = {{(n-3){1'b0}}, 3'b100};

  typedef enum logic {
    S_REQ   = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [n-1:0] pc;

  logic         capture;
  logic         deliver;
  logic         misaligned;
  logic [n-1:0] redirect_tgt;

  // An ack that coincides with a redirect belongs to the squashed path.
  assign capture      = (state == S_REQ) && imem_ack && !redirect;
  // A delivery still counts when a redirect arrives in the same cycle.
  assign deliver      = (state == S_VALID) && out_ready;
  assign misaligned   = redirect && (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = {redirect_pc[n-1:2], 2'b00};

  assign add_a     = pc;
  assign add_b     = FOUR;
  assign imem_addr = pc;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = S_REQ;
    end else begin
      case (state)
        S_REQ:   if (imem_ack)  state_nxt = S_VALID;
        S_VALID: if (out_ready) state_nxt = S_REQ;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    imem_req  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_REQ:   imem_req  = !reset;
      S_VALID: out_valid = 1'b1;
      default: begin
        imem_req  = 1'b0;
        out_valid = 1'b0;
      end
    endcase
  end

  // Program counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_tgt;
    end else if (capture) begin
      pc <= add_sum;
    end
  end

  // Output buffer: only a capture or reset changes it, so it stays stable
  // for as long as decode holds off.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_instr <= '0;
      out_pc    <= '0;
      out_pc4   <= '0;
    end else if (capture) begin
      out_instr <= imem_rdata;
      out_pc    <= pc;
      out_pc4   <= add_sum;
    end
  end

  // Sticky alignment error and delivery counter
  always_ff @(posedge clk) begin
    if (reset) begin
      align_err   <= 1'b0;
      fetch_count <= '0;
    end else begin
      if (misaligned) begin
        align_err <= 1'b1;
      end
      if (deliver) begin
        fetch_count <= fetch_count + ONE;
      end
    end
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that owns the program counter and sits directly upstream of the PC+4 `adder` instance. It drives the adder's operands, consumes its SUM as the sequential next PC, and fetches from instruction memory over a single-cycle req/ack handshake. It presents each instruction to decode through a valid/ready handshake, and accepts branch/jump redirects from later stages.

## Interface
- `n`, default 32: PC/address width. Must match the `n` of the attached `adder`.
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Must be 4-byte aligned.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `redirect`  in  1  taken branch/jump; has priority over everything except reset.
- `redirect_pc`  in  n  target PC, sampled when `redirect`=1.
- `add_a`  out  n  adder operand A; always equals the current PC.
- `add_b`  out  n  adder operand B; constant 4.
- `add_sum`  in  n  adder SUM (PC+4), combinational same cycle.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  n  fetch address; equals PC.
- `imem_ack`  in  1  memory returns `imem_rdata` for `imem_addr` this cycle.
- `imem_rdata`  in  32  instruction word.
- `out_valid`  out  1  buffered instruction available to decode.
- `out_ready`  in  1  decode accepts the instruction.
- `out_instr`  out  32  buffered instruction.
- `out_pc`  out  n  PC of `out_instr`.
- `out_pc4`  out  n  `out_pc`+4, captured from `add_sum`.
- `align_err`  out  1  sticky flag: a misaligned `redirect_pc` was received.
- `fetch_count`  out  n  number of instructions delivered to decode (`out_valid & out_ready`).

## Operation
- Two-state FSM: `S_REQ` fetches and `S_VALID` holds the buffered instruction.
- **S_REQ**
  - `imem_req` = ~`reset`, `imem_addr` = PC.
  - On `imem_ack`: capture `out_instr`←`imem_rdata`, `out_pc`←PC, `out_pc4`←`add_sum`; PC←`add_sum`; go to `S_VALID`.
  - Without `imem_ack`: stay in `S_REQ`, PC unchanged, req held.
- **S_VALID**
  - `out_valid`=1 and `imem_req`=0.
  - On `out_ready`: `fetch_count`++ and go to `S_REQ`.
  - Otherwise hold; all `out_*` stay stable.
- **Redirect** (any state)
  - PC←{`redirect_pc`[n-1:2], 2'b00}; state←`S_REQ`.
  - The buffered instruction is dropped: `out_valid`=0 next cycle.
  - An `imem_ack` in the same cycle is discarded and PC does not take `add_sum`.
  - If `out_valid & out_ready` coincide with `redirect`, the handshake still counts: `fetch_count`++.
- **Misaligned redirect**: if `redirect_pc`[1:0]≠0 while `redirect`=1, `align_err`←1 and stays set until reset. The target is still aligned as above.
- **Arithmetic**: PC wraps modulo 2^n through the adder, so `2^n-4` + 4 = 0 and fetch continues at 0. `fetch_count` wraps from 2^n-1 to 0.
- `add_a` and `add_b` are continuous assigns. The stage does no addition itself.

## Timing
- State, PC, and `out_*` are all set on the clock edge where `reset`=1. Reset values:
  - state=`S_REQ`, PC=`RESET_PC`
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `out_pc4`=0
  - `align_err`=0, `fetch_count`=0
- `imem_req` is forced to 0 during any cycle with `reset`=1. The first request is issued in the first cycle after `reset` deasserts.
- Fetch latency: an ack in `S_REQ` cycle t gives `out_valid`=1 in cycle t+1.
- Peak throughput is one instruction per 2 cycles (ack in t, accept in t+1, next req in t+2).
- Redirect in cycle t gives `imem_addr`=target in cycle t+1.
- Reset has priority over `redirect`. Reset mid-fetch or mid-hold returns to the reset state with no delivery and no count.
- `out_*` change only on capture or reset. Under `out_ready`=0 they are stable indefinitely.

## Test plan
- **Reset then straight-line fetch**: `RESET_PC`=0, `imem_ack`=1, `out_ready`=1.
  - `imem_addr` sequence 0, 4, 8 on alternate cycles.
  - `out_pc`/`out_pc4` = 0/4, 4/8, 8/12.
  - `fetch_count`=3 after the third accept.
- **Backpressure**: `out_ready`=0 for 5 cycles in `S_VALID`.
  - `out_instr`=32'hDEAD_BEEF held constant, `imem_req`=0, `fetch_count` unchanged.
  - Release: one count, then the next req.
- **Memory wait**: `imem_ack`=0 for 3 cycles.
  - `imem_req`=1 with `imem_addr`=0x10 held.
  - Ack on the 4th cycle gives `out_pc`=0x10 next cycle.
- **Redirect with simultaneous ack**: in `S_REQ` at PC=0x20, assert `redirect`=1, `redirect_pc`=0x100, and `imem_ack`=1.
  - No `out_valid` next cycle.
  - `imem_addr`=0x100.
  - Then `out_pc`=0x100.
- **Misaligned redirect and wrap**:
  - `redirect_pc`=0x0000_0106 gives `imem_addr`=0x104 and `align_err`=1, which stays set until reset.
  - Redirect to 0xFFFF_FFFC: `out_pc4`=0, next `imem_addr`=0.
- **Reset mid-hold**: `reset` asserted in `S_VALID` with `out_ready`=1.
  - `out_valid`=0, `fetch_count`=0, PC=`RESET_PC`.
  - `imem_req`=0 that cycle.
